// File: rtl/sm_add_seq_pkg.sv
// sm_add_seq_pkg
// Shared definitions for the sequential sign-magnitude adder:
//   - default operand width and chunk size
//   - FSM state encodings, kept as plain localparams so that older
//     code in the arithmetic set can reuse them unchanged
//   - a helper that locates the sign bit of a sign-magnitude word
package sm_add_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CONV = 3'd1;
  localparam logic [2:0] ST_ADD  = 3'd2;
  localparam logic [2:0] ST_FIN  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Index of the sign bit in a sign-magnitude word of the given width.
  function automatic int smSignBit(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/sm_chunk_add.sv
// sm_chunk_add
// Purely combinational CHUNK-bit adder with carry in and carry out.
// Ports:
//   a, b : CHUNK-bit addends
//   ci   : carry in
//   s    : CHUNK-bit sum
//   co   : carry out
module sm_chunk_add #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  // One extra bit on every operand so the carry falls out of the top.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/sm_add_seq.sv
// sm_add_seq
// Multi-cycle sign-magnitude adder/subtractor. Operands are accepted on a
// valid/ready handshake, converted to WIDTH+1-bit two's complement, added
// CHUNK bits per cycle through a registered carry, converted back to
// sign-magnitude (saturating on overflow) and offered on a second
// valid/ready handshake.
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid, in_ready  : operand handshake
//   op1, op2, sub       : sign-magnitude operands; sub=1 computes op1-op2
//   out_valid, out_ready: result handshake
//   sum, ovf            : sign-magnitude result and overflow flag
//   busy                : high whenever the FSM is not idle
module sm_add_seq
  import sm_add_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SIGN   = smSignBit(WIDTH);

  generate
    if (WIDTH % CHUNK != 0) begin : g_badChunk
      $error("sm_add_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic [WIDTH:0]   r_a;
  logic [WIDTH:0]   r_b;
  logic [WIDTH:0]   r_res;
  logic [CNTW-1:0]  r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf;

  logic [CHUNK-1:0] w_aChunk;
  logic [CHUNK-1:0] w_bChunk;
  logic [CHUNK-1:0] w_sumChunk;
  logic             w_carryOut;
  logic             w_lastChunk;
  logic             w_resNeg;
  logic [WIDTH:0]   w_resMag;
  logic             w_resOvf;
  logic [WIDTH-1:0] w_resSm;

  // Sign-magnitude to WIDTH+1-bit two's complement. The extra bit keeps
  // the full sum range representable; -0 negates to 0 naturally.
  function automatic logic [WIDTH:0] smToTwos(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] mag;
    mag = {2'b00, v[WIDTH-2:0]};
    return v[SIGN] ? -mag : mag;
  endfunction

  // Pick the chunk currently being added, LSB chunk first.
  always_comb begin
    w_aChunk = '0;
    w_bChunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_cnt == CNTW'(i)) begin
        w_aChunk = r_a[i*CHUNK +: CHUNK];
        w_bChunk = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  sm_chunk_add #(.CHUNK(CHUNK)) u_chunkAdd (
    .a  (w_aChunk),
    .b  (w_bChunk),
    .ci (r_carry),
    .s  (w_sumChunk),
    .co (w_carryOut)
  );

  assign w_lastChunk = (r_cnt == CNTW'(NCHUNK - 1));

  // Back-conversion: anything whose magnitude needs bit WIDTH-1 or above
  // no longer fits the sign-magnitude format and saturates.
  assign w_resNeg = r_res[WIDTH];
  assign w_resMag = w_resNeg ? -r_res : r_res;
  assign w_resOvf = |w_resMag[WIDTH:WIDTH-1];
  assign w_resSm  = w_resOvf ? {w_resNeg, {(WIDTH-1){1'b1}}}
                             : {w_resNeg, w_resMag[WIDTH-2:0]};

  // Main FSM with its datapath registers. sum/ovf are written only when
  // leaving FIN so they hold the last result through DONE and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op1   <= '0;
      r_op2   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op1   <= op1;
            r_op2   <= op2 ^ {sub, {(WIDTH-1){1'b0}}};
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_a     <= smToTwos(r_op1);
          r_b     <= smToTwos(r_op2);
          r_carry <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_ADD;
        end
        ST_ADD: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (r_cnt == CNTW'(i)) begin
              r_res[i*CHUNK +: CHUNK] <= w_sumChunk;
            end
          end
          r_carry <= w_carryOut;
          if (w_lastChunk) begin
            // The sign-extension bit rides on the final chunk's carry.
            r_res[WIDTH] <= r_a[WIDTH] ^ r_b[WIDTH] ^ w_carryOut;
            r_cnt        <= '0;
            r_state      <= ST_FIN;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        ST_FIN: begin
          r_sum   <= w_resSm;
          r_ovf   <= w_resOvf;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign sum       = r_sum;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_sm_add_seq.sv
// tb_sm_add_seq
// Directed bench for sm_add_seq with an arithmetic reference model and a
// per-cycle compare process.
module tb_sm_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  exp_t        q[$];
  logic [31:0] lastSum;
  logic        lastOvf;
  int          negCnt     = 0;
  int          accAt      = 0;
  bit          latChecked = 1'b1;

  sm_add_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: signed integer arithmetic on the decoded operands, then
  // re-encode with saturation.
  function automatic exp_t modelAdd(logic [31:0] a, logic [31:0] b, logic s);
    longint va, vb, r, mag;
    exp_t   e;
    va = longint'(a[30:0]);
    if (a[31]) va = -va;
    vb = longint'(b[30:0]);
    if (b[31] ^ s) vb = -vb;
    r   = va + vb;
    mag = (r < 0) ? -r : r;
    if (mag > 2147483647) begin
      e.sum = {(r < 0), 31'h7FFFFFFF};
      e.ovf = 1'b1;
    end else begin
      e.sum = {(r < 0), mag[30:0]};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting, want handshake", name);
  endtask

  // Called at posedge+1; returns at posedge+1 just after acceptance.
  task automatic applyStimulus(logic [31:0] a, logic [31:0] b, logic s);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) timeoutFail("accept");
    op1      = a;
    op2      = b;
    sub      = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output logic [31:0] s, output logic o);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) timeoutFail("result");
    s = sum;
    o = ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic runOp(string name, logic [31:0] a, logic [31:0] b, logic s,
                       logic [31:0] expSum, logic expOvf);
    logic [31:0] gotSum;
    logic        gotOvf;
    applyStimulus(a, b, s);
    waitResult(gotSum, gotOvf);
    checkOutput({name, "_sum"}, gotSum, expSum);
    checkOutput({name, "_ovf"}, gotOvf, expOvf);
  endtask

  // Per-cycle scoreboard: result contents and latency while out_valid,
  // retained result while idle, and busy/in_ready consistency.
  always @(negedge clk) begin
    negCnt++;
    if (!rst) begin
      checkOutput("busy_vs_ready", busy, !in_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL spurious_valid: got out_valid=1 want 0");
        end else begin
          if (!latChecked) begin
            checkOutput("latency", negCnt - accAt, 7);
            latChecked = 1'b1;
          end
          checkOutput("cmp_sum", sum, q[0].sum);
          checkOutput("cmp_ovf", ovf, q[0].ovf);
          if (out_ready) begin
            lastSum = q[0].sum;
            lastOvf = q[0].ovf;
            void'(q.pop_front());
          end
        end
      end
      if (in_ready) begin
        checkOutput("idle_sum", sum, lastSum);
        checkOutput("idle_ovf", ovf, lastOvf);
      end
      if (in_valid && in_ready) begin
        q.push_back(modelAdd(op1, op2, sub));
        accAt      = negCnt;
        latChecked = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        sawValid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op1       = '0;
    op2       = '0;
    sub       = 1'b0;
    lastSum   = '0;
    lastOvf   = 1'b0;

    // Pin the model with hand-worked values.
    checkOutput("model_a", modelAdd(32'h5, 32'h3, 1'b0), {32'h8, 1'b0});
    checkOutput("model_b", modelAdd(32'h5, 32'h80000007, 1'b0), {32'h80000002, 1'b0});
    checkOutput("model_c", modelAdd(32'h3, 32'h80000004, 1'b1), {32'h7, 1'b0});
    checkOutput("model_d", modelAdd(32'h80000000, 32'h80000000, 1'b0), {32'h0, 1'b0});
    checkOutput("model_e", modelAdd(32'hFFFFFFFF, 32'h80000001, 1'b0), {32'hFFFFFFFF, 1'b1});

    #3;
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_sum", sum, 32'h0);
    checkOutput("rst_ovf", ovf, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    runOp("add_pos",  32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0);
    runOp("add_mix",  32'h00000005, 32'h80000007, 1'b0, 32'h80000002, 1'b0);
    runOp("sub_neg",  32'h00000003, 32'h80000004, 1'b1, 32'h00000007, 1'b0);
    runOp("neg_zero", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0);
    runOp("ovf_pos",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1);
    runOp("ovf_neg",  32'hFFFFFFFF, 32'h80000001, 1'b0, 32'hFFFFFFFF, 1'b1);
    runOp("cancel",   32'h80000003, 32'h00000003, 1'b0, 32'h00000000, 1'b0);
    runOp("carry",    32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);
    runOp("sub_big",  32'h12345678, 32'h00ABCDEF, 1'b1, 32'h11888889, 1'b0);

    // Backpressure: hold DONE, poke in_valid, then release.
    out_ready = 1'b0;
    applyStimulus(32'h00000010, 32'h00000020, 1'b0);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (!out_valid) timeoutFail("bp_valid");
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = (i < 2);
      op1      = 32'h7FFFFFFF;
      op2      = 32'h7FFFFFFF;
      @(posedge clk);
      #1;
      checkOutput("bp_sum", sum, 32'h00000030);
      checkOutput("bp_ovf", ovf, 1'b0);
      checkOutput("bp_in_ready", in_ready, 1'b0);
      checkOutput("bp_busy", busy, 1'b1);
      checkOutput("bp_out_valid", out_valid, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_out_valid", out_valid, 1'b0);
    checkOutput("release_in_ready", in_ready, 1'b1);

    // Reset during the second ADD cycle discards the operation.
    applyStimulus(32'h00000100, 32'h00000200, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_in_ready", in_ready, 1'b1);
    checkOutput("abort_out_valid", out_valid, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_sum", sum, 32'h0);
    checkOutput("abort_ovf", ovf, 1'b0);
    q.delete();
    lastSum = '0;
    lastOvf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("abort_no_valid", sawValid, 1'b0);

    runOp("after_rst", 32'h00000002, 32'h00000002, 1'b0, 32'h00000004, 1'b0);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
